execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//  EX stage of the 5-stage RV32 pipeline: consumes the ID/EX register outputs of the decode stage.
//  Forwards operands, runs the ALU and resolves beq; drives PCSrcE/PCTargetE back to fetch.
//  Registers results into the EX/MEM pipeline register for the memory stage.
//  Keeps a saturating taken-branch counter for performance debug.
// PARAMETERS
//  DATA_W  32  datapath width (ALU, PC, immediates)
//  RA_W    5   register-address width
//  CNT_W   16  taken-branch counter width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       reset, asynchronous, active-low
//  RegWriteE    in   1       reg-file write enable from ID/EX
//  ALUSrcE      in   1       1: SrcB = Imm_Ext_E, 0: forwarded RD2
//  MemWriteE    in   1       data-memory write enable
//  ResultSrcE   in   1       WB select (0 ALU, 1 mem), passed through
//  BranchE      in   1       instruction is beq
//  ALUControlE  in   3       ALU op code
//  RD1_E/RD2_E  in   DATA_W  register operands
//  Imm_Ext_E    in   DATA_W  sign-extended immediate
//  RD_E         in   RA_W    destination register
//  PCE          in   DATA_W  PC of instruction in EX
//  PCPlus4E     in   DATA_W  PC+4 of instruction in EX
//  ForwardAE    in   2       SrcA select from hazard unit
//  ForwardBE    in   2       SrcB-pre-imm select from hazard unit
//  ResultW      in   DATA_W  writeback value (forward source)
//  PCSrcE       out  1       branch taken, combinational
//  PCTargetE    out  DATA_W  PCE + Imm_Ext_E, combinational
//  RegWriteM, MemWriteM, ResultSrcM  out 1 each  registered controls
//  RD_M         out  RA_W    registered destination
//  ALUResultM   out  DATA_W  registered ALU result (also EX-forward source)
//  WriteDataM   out  DATA_W  registered forwarded RD2 (store data)
//  PCPlus4M     out  DATA_W  registered PC+4
//  BrTakenCnt   out  CNT_W   taken-branch count
// BEHAVIOUR
//  - Forward mux A/B: 00 RD1_E/RD2_E, 01 ResultW, 10 ALUResultM (internal reg), 11 same as 00.
//  - SrcB = ALUSrcE ? Imm_Ext_E : forwarded RD2; WriteData = forwarded RD2 always.
//  - ALU: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 0/1); other codes -> 0.
//  - add/sub/PCTargetE wrap modulo 2^DATA_W; no overflow flag.
//  - Zero = (ALU result == 0); PCSrcE = BranchE & Zero; same cycle, no register.
//  - EX/MEM register: all M outputs load every rising clk edge; 1-cycle latency EX->M; no stall/enable.
//  - Reset (rst=0, async): all M outputs and BrTakenCnt -> 0 immediately, held until rst=1.
//  - Reset mid-operation discards the in-flight instruction; no write enables survive.
//  - BrTakenCnt: +1 on each rising edge with PCSrcE=1; saturates at 2^CNT_W-1, never wraps.
//  - X on controls while rst=0 must not reach outputs.
//  - Back-to-back dependency: a result in M this cycle is visible to EX this cycle via ForwardAE=10.
// TESTING
//  - add: RD1=5, Imm=7, ALUSrcE=1, ctl 000 -> next edge ALUResultM=12, RD_M=RD_E, RegWriteM=1.
//  - sub wrap: RD1=0, RD2=1, ctl 001 -> ALUResultM=32'hFFFFFFFF; slt -1<1 -> 1.
//  - forwarding: ALUResultM=9, ResultW=3; ForwardAE=10/ForwardBE=01, ctl 000 -> 12;
//    ForwardAE=11 -> uses RD1_E.
//  - beq: BranchE=1, RD1=RD2=4, PCE=0x100, Imm=-8 -> PCSrcE=1, PCTargetE=0xF8 same cycle,
//    BrTakenCnt +1; RD2=5 -> PCSrcE=0.
//  - async reset mid-stream: drop rst between edges -> all M outputs and counter 0 immediately.
//  - saturation: CNT_W=2, 5 taken branches -> BrTakenCnt stays 3.

Source files
------------

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32 pipeline: operand forwarding, ALU, beq resolution,
// EX/MEM pipeline register and a saturating taken-branch counter.
module execute_cycle #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [RA_W-1:0]   RD_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [RA_W-1:0]   RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [CNT_W-1:0]  BrTakenCnt
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] src_a_s;
  logic [DATA_W-1:0] fwd_b_s;
  logic [DATA_W-1:0] src_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              zero_s;
  logic              taken_s;

  logic              reg_write_m_r;
  logic              mem_write_m_r;
  logic              result_src_m_r;
  logic [RA_W-1:0]   rd_m_r;
  logic [DATA_W-1:0] alu_result_m_r;
  logic [DATA_W-1:0] write_data_m_r;
  logic [DATA_W-1:0] pc_plus4_m_r;
  logic [CNT_W-1:0]  br_cnt_r;

  // Forward mux A: the M-stage result is taken from our own EX/MEM register.
  always_comb begin
    src_a_s = RD1_E;
    case (ForwardAE)
      FWD_W:   src_a_s = ResultW;
      FWD_M:   src_a_s = alu_result_m_r;
      default: src_a_s = RD1_E;
    endcase
  end

  // Forward mux B, ahead of the immediate select; this value is also the store data.
  always_comb begin
    fwd_b_s = RD2_E;
    case (ForwardBE)
      FWD_W:   fwd_b_s = ResultW;
      FWD_M:   fwd_b_s = alu_result_m_r;
      default: fwd_b_s = RD2_E;
    endcase
  end

  assign src_b_s = ALUSrcE ? Imm_Ext_E : fwd_b_s;

  // ALU; undefined op codes produce zero.
  always_comb begin
    alu_result_s = {DATA_W{1'b0}};
    case (ALUControlE)
      ALU_ADD: alu_result_s = src_a_s + src_b_s;
      ALU_SUB: alu_result_s = src_a_s - src_b_s;
      ALU_AND: alu_result_s = src_a_s & src_b_s;
      ALU_OR:  alu_result_s = src_a_s | src_b_s;
      ALU_SLT: begin
        if ($signed(src_a_s) < $signed(src_b_s)) begin
          alu_result_s = DATA_ONE;
        end else begin
          alu_result_s = {DATA_W{1'b0}};
        end
      end
      default: alu_result_s = {DATA_W{1'b0}};
    endcase
  end

  assign zero_s    = (alu_result_s == {DATA_W{1'b0}});
  assign taken_s   = BranchE & zero_s;
  assign PCSrcE    = taken_s;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM pipeline register, loaded every cycle; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_m_r  <= 1'b0;
      mem_write_m_r  <= 1'b0;
      result_src_m_r <= 1'b0;
      rd_m_r         <= {RA_W{1'b0}};
      alu_result_m_r <= {DATA_W{1'b0}};
      write_data_m_r <= {DATA_W{1'b0}};
      pc_plus4_m_r   <= {DATA_W{1'b0}};
    end else begin
      reg_write_m_r  <= RegWriteE;
      mem_write_m_r  <= MemWriteE;
      result_src_m_r <= ResultSrcE;
      rd_m_r         <= RD_E;
      alu_result_m_r <= alu_result_s;
      write_data_m_r <= fwd_b_s;
      pc_plus4_m_r   <= PCPlus4E;
    end
  end

  // Taken-branch counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_r <= {CNT_W{1'b0}};
    end else if (taken_s && (br_cnt_r != CNT_MAX)) begin
      br_cnt_r <= br_cnt_r + CNT_ONE;
    end else begin
      br_cnt_r <= br_cnt_r;
    end
  end

  assign RegWriteM  = reg_write_m_r;
  assign MemWriteM  = mem_write_m_r;
  assign ResultSrcM = result_src_m_r;
  assign RD_M       = rd_m_r;
  assign ALUResultM = alu_result_m_r;
  assign WriteDataM = write_data_m_r;
  assign PCPlus4M   = pc_plus4_m_r;
  assign BrTakenCnt = br_cnt_r;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: scoreboard of expected EX/MEM contents,
// plus a second instance with a 2-bit counter for saturation.
module tb_execute_cycle;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite, alusrc, memwrite, resultsrc, branch;
  logic [2:0]  aluctl;
  logic [31:0] rd1, rd2, imm, pce, pc4, resultw;
  logic [4:0]  rd;
  logic [1:0]  fa, fb;

  logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic [15:0] BrTakenCnt;

  logic        s_pcsrc, s_rw, s_mw, s_rs;
  logic [31:0] s_tgt, s_alu, s_wd, s_pc4;
  logic [4:0]  s_rd;
  logic [1:0]  s_cnt;

  m_t   q[$];
  m_t   exp_m;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  exp_sat = 2'd0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst), .RegWriteE(regwrite), .ALUSrcE(alusrc), .MemWriteE(memwrite),
    .ResultSrcE(resultsrc), .BranchE(branch), .ALUControlE(aluctl), .RD1_E(rd1), .RD2_E(rd2),
    .Imm_Ext_E(imm), .RD_E(rd), .PCE(pce), .PCPlus4E(pc4), .ForwardAE(fa), .ForwardBE(fb),
    .ResultW(resultw), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .BrTakenCnt(BrTakenCnt)
  );

  execute_cycle #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .RegWriteE(regwrite), .ALUSrcE(alusrc), .MemWriteE(memwrite),
    .ResultSrcE(resultsrc), .BranchE(branch), .ALUControlE(aluctl), .RD1_E(rd1), .RD2_E(rd2),
    .Imm_Ext_E(imm), .RD_E(rd), .PCE(pce), .PCPlus4E(pc4), .ForwardAE(fa), .ForwardBE(fb),
    .ResultW(resultw), .PCSrcE(s_pcsrc), .PCTargetE(s_tgt), .RegWriteM(s_rw),
    .MemWriteM(s_mw), .ResultSrcM(s_rs), .RD_M(s_rd), .ALUResultM(s_alu),
    .WriteDataM(s_wd), .PCPlus4M(s_pc4), .BrTakenCnt(s_cnt)
  );

  function automatic m_t act_m();
    return {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
  endfunction

  task automatic set_defaults();
    regwrite = 1'b0; alusrc = 1'b0; memwrite = 1'b0; resultsrc = 1'b0; branch = 1'b0;
    aluctl = 3'b000; rd1 = 32'd0; rd2 = 32'd0; imm = 32'd0; pce = 32'd0; pc4 = 32'd4;
    rd = 5'd0; fa = 2'b00; fb = 2'b00; resultw = 32'd0;
  endtask

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] wd);
    q.push_back({regwrite, memwrite, resultsrc, rd, alu, wd, pc4});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (q.size() > 0) exp_m = q.pop_front();
    else exp_m = 'x;
  endtask

  task automatic count_taken();
    exp_cnt = exp_cnt + 16'd1;
    if (exp_sat != 2'd3) exp_sat = exp_sat + 2'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    regwrite = 1'bx; memwrite = 1'bx; resultsrc = 1'bx; branch = 1'bx; alusrc = 1'bx;
    aluctl = 3'bxxx; rd1 = 'x; rd2 = 'x; imm = 'x; rd = 'x; pc4 = 'x; fa = 2'bxx; fb = 2'bxx;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (act_m() !== '0 || BrTakenCnt !== 16'd0 || s_cnt !== 2'd0)
      $display("FAIL reset: got m=%h cnt=%h sat=%h, expected all zero", act_m(), BrTakenCnt, s_cnt);
    else n_pass++;
    set_defaults();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_ops();
    logic [31:0] a_t[6]  = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_F0F0, 32'd7};
    logic [31:0] b_t[6]  = '{32'h55, 32'd1, 32'd1, 32'h0000_FF00, 32'h0000_FF00, 32'd3};
    logic [2:0]  c_t[6]  = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b011, 3'b111};
    logic [31:0] e_t[6]  = '{32'd12, 32'hFFFF_FFFF, 32'd1, 32'h0000_F000, 32'h0000_FFF0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      set_defaults();
      rd1 = a_t[i]; rd2 = b_t[i]; aluctl = c_t[i];
      alusrc = (i == 0); imm = 32'd7;
      regwrite = 1'b1; memwrite = (i == 1); resultsrc = (i == 2);
      rd = 5'd10 + 5'(i); pce = 32'h40 + 32'(i * 4); pc4 = pce + 32'd4;
      #1;
      n_checks++;
      if (PCTargetE !== pce + 32'd7 || PCSrcE !== 1'b0)
        $display("FAIL alu_target[%0d]: got tgt=%h src=%b, expected tgt=%h src=0", i, PCTargetE, PCSrcE, pce + 32'd7);
      else n_pass++;
      push_exp(e_t[i], b_t[i]);
      advance();
      n_checks++;
      if (act_m() !== exp_m) $display("FAIL alu_op[%0d]: got %h expected %h", i, act_m(), exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_forwarding();
    set_defaults();
    rd1 = 32'd9; alusrc = 1'b1; imm = 32'd0; regwrite = 1'b1; rd = 5'd3;
    push_exp(32'd9, 32'd0);
    advance();
    n_checks++;
    if (act_m() !== exp_m) $display("FAIL fwd_setup: got %h expected %h", act_m(), exp_m);
    else n_pass++;
    set_defaults();
    rd1 = 32'd100; rd2 = 32'd50; resultw = 32'd3; fa = 2'b10; fb = 2'b01; rd = 5'd4;
    push_exp(32'd12, 32'd3);
    advance();
    n_checks++;
    if (act_m() !== exp_m) $display("FAIL fwd_m_w: got %h expected %h", act_m(), exp_m);
    else n_pass++;
    set_defaults();
    rd1 = 32'd100; rd2 = 32'd1; resultw = 32'd3; fa = 2'b11; fb = 2'b00; rd = 5'd5;
    push_exp(32'd101, 32'd1);
    advance();
    n_checks++;
    if (act_m() !== exp_m) $display("FAIL fwd_11: got %h expected %h", act_m(), exp_m);
    else n_pass++;
  endtask

  task automatic test_beq();
    set_defaults();
    branch = 1'b1; rd1 = 32'd4; rd2 = 32'd4; aluctl = 3'b001; pce = 32'h100;
    imm = 32'hFFFF_FFF8; pc4 = 32'h104;
    #1;
    n_checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h0000_00F8)
      $display("FAIL beq_taken: got src=%b tgt=%h, expected src=1 tgt=000000f8", PCSrcE, PCTargetE);
    else n_pass++;
    push_exp(32'd0, 32'd4);
    advance();
    count_taken();
    n_checks++;
    if (act_m() !== exp_m || BrTakenCnt !== exp_cnt)
      $display("FAIL beq_taken_m: got %h cnt=%h expected %h cnt=%h", act_m(), BrTakenCnt, exp_m, exp_cnt);
    else n_pass++;
    rd2 = 32'd5;
    #1;
    n_checks++;
    if (PCSrcE !== 1'b0) $display("FAIL beq_not_taken: got src=%b expected 0", PCSrcE);
    else n_pass++;
    push_exp(32'hFFFF_FFFF, 32'd5);
    advance();
    n_checks++;
    if (act_m() !== exp_m || BrTakenCnt !== exp_cnt)
      $display("FAIL beq_nt_m: got %h cnt=%h expected %h cnt=%h", act_m(), BrTakenCnt, exp_m, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      set_defaults();
      fa = (i == 1) ? 2'b00 : 2'b10;
      rd1 = 32'd0; alusrc = 1'b1; imm = 32'(i); regwrite = 1'b1; rd = 5'd7;
      acc = acc + 32'(i);
      push_exp(acc, 32'd0);
      advance();
      n_checks++;
      if (act_m() !== exp_m) $display("FAIL b2b[%0d]: got %h expected %h", i, act_m(), exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_defaults();
      branch = 1'b1; rd1 = 32'd0; rd2 = 32'd0;
      push_exp(32'd0, 32'd0);
      advance();
      count_taken();
      n_checks++;
      if (s_cnt !== exp_sat || BrTakenCnt !== exp_cnt || act_m() !== exp_m)
        $display("FAIL sat[%0d]: got sat=%h cnt=%h m=%h expected sat=%h cnt=%h m=%h",
                 i, s_cnt, BrTakenCnt, act_m(), exp_sat, exp_cnt, exp_m);
      else n_pass++;
    end
    n_checks++;
    if (s_cnt !== 2'd3) $display("FAIL sat_final: got %h expected 3", s_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    set_defaults();
    regwrite = 1'b1; memwrite = 1'b1; branch = 1'b1; rd1 = 32'd6; rd2 = 32'd6; rd = 5'd9;
    aluctl = 3'b001;
    push_exp(32'd0, 32'd6);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    exp_cnt = 16'd0; exp_sat = 2'd0;
    n_checks++;
    if (act_m() !== '0 || BrTakenCnt !== exp_cnt || s_cnt !== exp_sat)
      $display("FAIL rst_async: got m=%h cnt=%h sat=%h expected zero", act_m(), BrTakenCnt, s_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (act_m() !== '0 || BrTakenCnt !== exp_cnt)
      $display("FAIL rst_hold: got m=%h cnt=%h expected zero", act_m(), BrTakenCnt);
    else n_pass++;
    set_defaults();
    @(negedge clk);
    rst = 1'b1;
    rd1 = 32'd20; alusrc = 1'b1; imm = 32'd22; regwrite = 1'b1; rd = 5'd1;
    push_exp(32'd42, 32'd0);
    advance();
    n_checks++;
    if (act_m() !== exp_m || BrTakenCnt !== exp_cnt)
      $display("FAIL rst_recover: got %h cnt=%h expected %h cnt=%h", act_m(), BrTakenCnt, exp_m, exp_cnt);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    set_defaults();
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_beq();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
